// File: rtl/vm_ui_pkg.sv
// Shared UI geometry, area codes and colours for the vending-machine
// display overlay and the touch decoder.
package vm_ui_pkg;

   localparam logic [4:0] AREA_NONE = 5'd0;
   localparam logic [4:0] HALF_YUAN = 5'd13;
   localparam logic [4:0] ONE_YUAN  = 5'd14;
   localparam logic [4:0] FIVE_YUAN = 5'd15;
   localparam logic [4:0] WITHDRAW  = 5'd16;
   localparam logic [4:0] CONFIRM   = 5'd17;
   localparam logic [4:0] CANCEL    = 5'd18;

   // Goods grid: all bounds are exclusive.
   localparam logic [15:0] GOODS_X_LO [4] = '{16'd10, 16'd160, 16'd310, 16'd460};
   localparam logic [15:0] GOODS_X_HI [4] = '{16'd150, 16'd300, 16'd450, 16'd600};
   localparam logic [15:0] GOODS_Y_LO [3] = '{16'd10, 16'd180, 16'd350};
   localparam logic [15:0] GOODS_Y_HI [3] = '{16'd140, 16'd310, 16'd480};

   // Coin row: one shared y band, three x bands.
   localparam logic [15:0] COIN_Y_LO = 16'd70;
   localparam logic [15:0] COIN_Y_HI = 16'd135;
   localparam logic [15:0] COIN_X_LO [3] = '{16'd610, 16'd670, 16'd730};
   localparam logic [15:0] COIN_X_HI [3] = '{16'd660, 16'd720, 16'd780};

   localparam logic [23:0] BTN_GOODS  = 24'h3060C0;
   localparam logic [23:0] BTN_COIN   = 24'hC0A020;
   localparam logic [23:0] BTN_OPTION = 24'h20A040;
   localparam logic [23:0] HILITE     = 24'hFFFF00;

   typedef enum logic [1:0] {
      CLS_NONE,
      CLS_GOODS,
      CLS_COIN,
      CLS_OPTION
   } region_cls_e;

   function automatic region_cls_e region_class(input logic [4:0] code);
      if (code == AREA_NONE)      return CLS_NONE;
      else if (code < HALF_YUAN)  return CLS_GOODS;
      else if (code < WITHDRAW)   return CLS_COIN;
      else                        return CLS_OPTION;
   endfunction

   // Per-channel average; the 9-bit sum is shifted back into 8 bits.
   function automatic logic [23:0] blend_rgb(input logic [23:0] a, input logic [23:0] b);
      logic [8:0]  s;
      logic [23:0] r;
      r = '0;
      for (int i = 0; i < 3; i++) begin
         s = {1'b0, a[i*8 +: 8]} + {1'b0, b[i*8 +: 8]};
         r[i*8 +: 8] = s[8:1];
      end
      return r;
   endfunction

endpackage

// File: rtl/vm_region_lookup.sv
// Scan position -> button region code, registered (pipeline stage 1).
// Lowest code wins where regions overlap; shared with the touch decoder.
module vm_region_lookup
   import vm_ui_pkg::*;
#(
   parameter int OPTION_X = 605,
   parameter int OPTION_Y = 70
)(
   input  logic        clk,
   input  logic        rstn,
   input  logic [15:0] i_x,
   input  logic [15:0] i_y,
   output logic [4:0]  o_region
);

   localparam logic [15:0] OPT_X_LO  = 16'(OPTION_X + 7);
   localparam logic [15:0] OPT_X_HI  = 16'(OPTION_X + 125);
   localparam logic [15:0] OPT_Y0_LO = 16'(OPTION_Y + 87);
   localparam logic [15:0] OPT_Y0_HI = 16'(OPTION_Y + 141);
   localparam logic [15:0] OPT_Y1_LO = 16'(OPTION_Y + 166);
   localparam logic [15:0] OPT_Y1_HI = 16'(OPTION_Y + 221);
   localparam logic [15:0] OPT_Y2_LO = 16'(OPTION_Y + 245);
   localparam logic [15:0] OPT_Y2_HI = 16'(OPTION_Y + 299);

   logic [1:0] w_col;
   logic [1:0] w_row;
   logic       w_col_ok;
   logic       w_row_ok;
   logic [4:0] w_coin;
   logic [4:0] w_region;

   // Combinational geometry decode, goods first so the lowest code wins.
   always_comb begin
      w_col    = '0;
      w_row    = '0;
      w_col_ok = 1'b0;
      w_row_ok = 1'b0;
      w_coin   = AREA_NONE;
      w_region = AREA_NONE;
      for (int c = 0; c < 4; c++) begin
         if (i_x > GOODS_X_LO[c] && i_x < GOODS_X_HI[c]) begin
            w_col_ok = 1'b1;
            w_col    = 2'(c);
         end
      end
      for (int r = 0; r < 3; r++) begin
         if (i_y > GOODS_Y_LO[r] && i_y < GOODS_Y_HI[r]) begin
            w_row_ok = 1'b1;
            w_row    = 2'(r);
         end
      end
      for (int k = 0; k < 3; k++) begin
         if (i_x > COIN_X_LO[k] && i_x < COIN_X_HI[k])
            w_coin = HALF_YUAN + 5'(k);
      end
      if (w_col_ok && w_row_ok)
         w_region = 5'd1 + {1'b0, w_row, 2'b00} + {3'b000, w_col};
      else if (i_y > COIN_Y_LO && i_y < COIN_Y_HI && w_coin != AREA_NONE)
         w_region = w_coin;
      else if (i_x > OPT_X_LO && i_x < OPT_X_HI) begin
         if (i_y > OPT_Y0_LO && i_y < OPT_Y0_HI)      w_region = WITHDRAW;
         else if (i_y > OPT_Y1_LO && i_y < OPT_Y1_HI) w_region = CONFIRM;
         else if (i_y > OPT_Y2_LO && i_y < OPT_Y2_HI) w_region = CANCEL;
      end
   end

   // Stage-1 register of the region code.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) o_region <= AREA_NONE;
      else       o_region <= w_region;
   end

endmodule

// File: rtl/vm_button_overlay.sv
// Button overlay for the vending-machine LCD: paints button fills over the
// background and highlights the last touched area for HOLD_FRAMES frames.
// Highlight changes are applied only at frame_start (tear-free).
// Build option: VM_OVERLAY_BLEND_EN -> non-highlight fills are averaged
// with the background instead of opaque.
module vm_button_overlay
   import vm_ui_pkg::*;
#(
   parameter int HOLD_FRAMES = 15,
   parameter int OPTION_X    = 605,
   parameter int OPTION_Y    = 70
)(
   input  logic        clk,
   input  logic        rstn,
   input  logic [15:0] pix_x,
   input  logic [15:0] pix_y,
   input  logic        pix_de,
   input  logic        frame_start,
   input  logic [23:0] bg_rgb,
   input  logic [4:0]  area_flag,
   output logic [23:0] rgb_out,
   output logic        de_out,
   output logic [4:0]  region_id,
   output logic [4:0]  active_area
);

   localparam int HW = $clog2(HOLD_FRAMES + 1);

   logic [4:0]    w_region1;
   logic          r_de1;
   logic [23:0]   r_bg1;
   logic [23:0]   w_rgb;
   logic [23:0]   w_fill;
   logic [4:0]    r_last_flag;
   logic [4:0]    r_pend_area;
   logic          r_pend_valid;
   logic [HW-1:0] r_hold;
   logic          w_new_event;

   vm_region_lookup #(
      .OPTION_X (OPTION_X),
      .OPTION_Y (OPTION_Y)
   ) u_lookup (
      .clk      (clk),
      .rstn     (rstn),
      .i_x      (pix_x),
      .i_y      (pix_y),
      .o_region (w_region1)
   );

   // Stage 1: de and background travel alongside the registered region.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_de1 <= 1'b0;
         r_bg1 <= '0;
      end else begin
         r_de1 <= pix_de;
         r_bg1 <= bg_rgb;
      end
   end

   // Colour select for the stage-1 pixel.
   always_comb begin
      case (region_class(w_region1))
         CLS_GOODS: w_fill = BTN_GOODS;
         CLS_COIN:  w_fill = BTN_COIN;
         default:   w_fill = BTN_OPTION;
      endcase
      if (!r_de1)
         w_rgb = '0;
      else if (w_region1 == AREA_NONE)
         w_rgb = r_bg1;
      else if (w_region1 == active_area)
         w_rgb = HILITE;
      else
`ifdef VM_OVERLAY_BLEND_EN
         w_rgb = blend_rgb(r_bg1, w_fill);
`else
         w_rgb = w_fill;
`endif
   end

   // Stage 2: composited pixel and aligned qualifiers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rgb_out   <= '0;
         de_out    <= 1'b0;
         region_id <= AREA_NONE;
      end else begin
         rgb_out   <= w_rgb;
         de_out    <= r_de1;
         region_id <= w_region1;
      end
   end

   assign w_new_event = (area_flag != AREA_NONE) && (area_flag != r_last_flag);

   // Touch capture and frame-synchronous highlight/hold update.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_last_flag  <= AREA_NONE;
         r_pend_area  <= AREA_NONE;
         r_pend_valid <= 1'b0;
         r_hold       <= '0;
         active_area  <= AREA_NONE;
      end else begin
         r_last_flag <= area_flag;
         if (w_new_event) begin
            r_pend_area  <= area_flag;
            r_pend_valid <= 1'b1;
         end
         if (frame_start) begin
            if (r_pend_valid || w_new_event) begin
               active_area  <= w_new_event ? area_flag : r_pend_area;
               r_hold       <= HW'(HOLD_FRAMES);
               r_pend_valid <= 1'b0;
            end else if (r_hold > HW'(1)) begin
               r_hold <= r_hold - HW'(1);
            end else if (r_hold == HW'(1)) begin
               r_hold      <= '0;
               active_area <= AREA_NONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_vm_button_overlay.sv
// Directed bench for vm_button_overlay: geometry, colour select, touch
// capture, highlight hold and mid-frame reset.
module tb_vm_button_overlay;
   import vm_ui_pkg::*;

   logic        clk;
   logic        rstn;
   logic [15:0] pix_x;
   logic [15:0] pix_y;
   logic        pix_de;
   logic        frame_start;
   logic [23:0] bg_rgb;
   logic [4:0]  area_flag;
   logic [23:0] rgb_out;
   logic        de_out;
   logic [4:0]  region_id;
   logic [4:0]  active_area;

   int total = 0;
   int bad   = 0;

   vm_button_overlay #(
      .HOLD_FRAMES (15),
      .OPTION_X    (605),
      .OPTION_Y    (70)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_de      (pix_de),
      .frame_start (frame_start),
      .bg_rgb      (bg_rgb),
      .area_flag   (area_flag),
      .rgb_out     (rgb_out),
      .de_out      (de_out),
      .region_id   (region_id),
      .active_area (active_area)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one pixel and wait out the 2-cycle latency.
   task automatic pix(input int x, input int y, input logic de, input logic [23:0] bg);
      pix_x  = 16'(x);
      pix_y  = 16'(y);
      pix_de = de;
      bg_rgb = bg;
      step();
      step();
   endtask

   task automatic frame();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   initial begin
      rstn        = 1'b0;
      pix_x       = '0;
      pix_y       = '0;
      pix_de      = 1'b0;
      frame_start = 1'b0;
      bg_rgb      = '0;
      area_flag   = '0;
      #23;
      chk("rst_rgb",    32'(rgb_out),     32'h0);
      chk("rst_de",     32'(de_out),      32'h0);
      chk("rst_region", 32'(region_id),   32'h0);
      chk("rst_active", 32'(active_area), 32'h0);
      rstn = 1'b1;
      step();

      // Geometry and colour select
      pix(80, 75, 1'b1, 24'h123456);
      chk("g1_region", 32'(region_id), 32'd1);
      chk("g1_de",     32'(de_out),    32'd1);
`ifdef VM_OVERLAY_BLEND_EN
      chk("g1_rgb",    32'(rgb_out),   32'h214A8B);
`else
      chk("g1_rgb",    32'(rgb_out),   32'h3060C0);
`endif
      pix(10, 75, 1'b1, 24'h123456);
      chk("edge10_region", 32'(region_id), 32'd0);
      chk("edge10_rgb",    32'(rgb_out),   32'h123456);
      pix(150, 75, 1'b1, 24'h654321);
      chk("edge150_region", 32'(region_id), 32'd0);
      chk("edge150_rgb",    32'(rgb_out),   32'h654321);
      pix(611, 71, 1'b1, 24'h000000);
      chk("coin13_region", 32'(region_id), 32'd13);
`ifndef VM_OVERLAY_BLEND_EN
      chk("coin13_rgb",    32'(rgb_out),   32'hC0A020);
`endif
      pix(779, 134, 1'b1, 24'h0);
      chk("coin15_region", 32'(region_id), 32'd15);
      pix(200, 200, 1'b1, 24'h0);
      chk("g6_region", 32'(region_id), 32'd6);
      pix(590, 470, 1'b1, 24'h0);
      chk("g12_region", 32'(region_id), 32'd12);
      pix(700, 160, 1'b1, 24'h0);
      chk("opt16_region", 32'(region_id), 32'd16);
`ifndef VM_OVERLAY_BLEND_EN
      chk("opt16_rgb",    32'(rgb_out),   32'h20A040);
`endif
      pix(700, 250, 1'b1, 24'h0);
      chk("opt17_region", 32'(region_id), 32'd17);
      pix(700, 320, 1'b1, 24'h0);
      chk("opt18_region", 32'(region_id), 32'd18);
      pix(612, 160, 1'b1, 24'h0);
      chk("opt_xedge_region", 32'(region_id), 32'd0);
      pix(80, 75, 1'b0, 24'h123456);
      chk("de0_rgb", 32'(rgb_out), 32'h0);
      chk("de0_de",  32'(de_out),  32'h0);

      // Touch 0 -> 6 mid-frame, then 15-frame hold
      area_flag = 5'd6;
      step(); step(); step();
      chk("t6_before_frame", 32'(active_area), 32'd0);
      frame();
      chk("t6_loaded", 32'(active_area), 32'd6);
      pix(200, 200, 1'b1, 24'h0);
      chk("t6_hilite", 32'(rgb_out), 32'hFFFF00);
      for (int f = 2; f <= 15; f++) begin
         frame();
         chk("t6_held", 32'(active_area), 32'd6);
      end
      frame();
      chk("t6_expired", 32'(active_area), 32'd0);
      pix(200, 200, 1'b1, 24'h0);
`ifndef VM_OVERLAY_BLEND_EN
      chk("t6_goods_again", 32'(rgb_out), 32'h3060C0);
`else
      chk("t6_goods_again", 32'(rgb_out), 32'h183060);
`endif

      // 6 then 9 within one frame: only 9 is shown
      area_flag = 5'd0; step();
      area_flag = 5'd6; step();
      area_flag = 5'd9; step();
      step();
      chk("t9_before_frame", 32'(active_area), 32'd0);
      frame();
      chk("t9_loaded", 32'(active_area), 32'd9);
      for (int f = 2; f <= 15; f++) frame();
      chk("t9_frame15", 32'(active_area), 32'd9);
      frame();
      chk("t9_expired", 32'(active_area), 32'd0);

      // 0 -> 17 coincident with frame_start; hold for 40 frames
      area_flag = 5'd0; step();
      area_flag   = 5'd17;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("t17_same_cycle", 32'(active_area), 32'd17);
      for (int f = 2; f <= 15; f++) frame();
      chk("t17_frame15", 32'(active_area), 32'd17);
      frame();
      chk("t17_expired", 32'(active_area), 32'd0);
      for (int f = 17; f <= 40; f++) frame();
      chk("t17_no_retrigger", 32'(active_area), 32'd0);

      // Reset during active video with hold = 7
      area_flag = 5'd0; step();
      area_flag = 5'd6; step();
      frame();
      for (int f = 0; f < 8; f++) frame();
      chk("rst_pre_active", 32'(active_area), 32'd6);
      pix(200, 200, 1'b1, 24'h0);
      chk("rst_pre_rgb", 32'(rgb_out), 32'hFFFF00);
      #2;
      rstn      = 1'b0;
      area_flag = 5'd0;
      #1;
      chk("midrst_rgb",    32'(rgb_out),     32'h0);
      chk("midrst_de",     32'(de_out),      32'h0);
      chk("midrst_region", 32'(region_id),   32'h0);
      chk("midrst_active", 32'(active_area), 32'h0);
      step();
      rstn   = 1'b1;
      pix_x  = 16'd5;
      pix_y  = 16'd5;
      pix_de = 1'b1;
      bg_rgb = 24'hABCDEF;
      step();
      chk("refill_de_1", 32'(de_out), 32'h0);
      step();
      chk("refill_de_2",  32'(de_out),  32'h1);
      chk("refill_rgb_2", 32'(rgb_out), 32'hABCDEF);
      pix(200, 200, 1'b1, 24'h0);
`ifndef VM_OVERLAY_BLEND_EN
      chk("refill_no_hilite", 32'(rgb_out), 32'h3060C0);
`else
      chk("refill_no_hilite", 32'(rgb_out), 32'h183060);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
